ixu_reg_file: RTL and testbench

//  Shared integer register file on the far side of the IXU read/write interface. It

---
 rtl/ixu_reg_file.sv | 117 +++++++++++
 tb/tb_ixu_reg_file.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ixu_reg_file.sv
// Shared integer register file for the IXU lanes.
// Each lane has two combinational read ports (rs1/rs2) and one write port.
// Reads see same-cycle writes through a bypass; the highest-numbered lane wins
// both the bypass and the commit when several lanes target one register.
// x0 is hardwired to zero. A sticky flag records same-cycle write collisions
// on a nonzero register, and latches the lowest colliding address from the
// first cycle in which a collision occurs.
// Handshake: there is no valid/ready pair; reads are answered in the same
// cycle, and any lane with wr_en=1 at a rising clock edge commits at that edge.
module ixu_reg_file #(
  parameter int NUM_LANES = 2,
  parameter int NUM_REGS  = 32,
  parameter int XLEN      = 32,
  parameter int AW        = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_LANES*AW-1:0]   rs1_addr,
  input  logic [NUM_LANES*AW-1:0]   rs2_addr,
  output logic [NUM_LANES*XLEN-1:0] rs1_data,
  output logic [NUM_LANES*XLEN-1:0] rs2_data,
  input  logic [NUM_LANES-1:0]      wr_en,
  input  logic [NUM_LANES*AW-1:0]   wr_addr,
  input  logic [NUM_LANES*XLEN-1:0] wr_data,
  output logic                      wr_conflict,
  output logic [AW-1:0]             wr_conflict_reg
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [XLEN-1:0]      regs [NUM_REGS];
  logic [NUM_LANES-1:0] wr_act;
  logic                 conf_now;
  logic [AW-1:0]        conf_addr;

  // Addresses beyond the implemented register count behave like x0.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NUM_REGS));
  endfunction

  // Array value of a register, overridden by the highest-numbered lane
  // writing it this cycle; x0, out-of-range and reset all read as zero.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if (rst && (a != '0) && in_range(a)) begin
      v = regs[a[IW-1:0]];
      for (int l = 0; l < NUM_LANES; l++) begin
        if (wr_act[l] && (wr_addr[l*AW +: AW] == a)) begin
          v = wr_data[l*XLEN +: XLEN];
        end
      end
    end
    return v;
  endfunction

  // A lane write is effective only when enabled, nonzero and in range.
  always_comb begin
    wr_act = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      wr_act[l] = wr_en[l] && (wr_addr[l*AW +: AW] != '0) && in_range(wr_addr[l*AW +: AW]);
    end
  end

  // Serve all read ports combinationally from array state plus bypass.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      rs1_data[l*XLEN +: XLEN] = read_port(rs1_addr[l*AW +: AW]);
      rs2_data[l*XLEN +: XLEN] = read_port(rs2_addr[l*AW +: AW]);
    end
  end

  // Detect lane pairs hitting the same register; keep the lowest such address.
  always_comb begin
    conf_now  = 1'b0;
    conf_addr = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (wr_act[i] && wr_act[j] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
          if (!conf_now || (wr_addr[i*AW +: AW] < conf_addr)) begin
            conf_now  = 1'b1;
            conf_addr = wr_addr[i*AW +: AW];
          end
        end
      end
    end
  end

  // Commit writes in ascending lane order so the highest lane's data lands last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (wr_act[l]) begin
          regs[wr_addr[l*AW + IW - 1 -: IW]] <= wr_data[l*XLEN +: XLEN];
        end
      end
    end
  end

  // Sticky conflict flag; the address is captured only on the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_conflict     <= 1'b0;
      wr_conflict_reg <= '0;
    end else if (conf_now && !wr_conflict) begin
      wr_conflict     <= 1'b1;
      wr_conflict_reg <= conf_addr;
    end
  end

endmodule

// File: tb/tb_ixu_reg_file.sv
// Bench for ixu_reg_file: directed scenarios followed by randomized traffic,
// checked against an array-based reference model through an expected queue.
module tb_ixu_reg_file;

  localparam int L = 2;
  localparam int N = 32;
  localparam int X = 32;
  localparam int A = 5;
  localparam int W = 4*X + 1 + A;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  logic [L*A-1:0] rs1_addr = '0;
  logic [L*A-1:0] rs2_addr = '0;
  logic [L*X-1:0] rs1_data;
  logic [L*X-1:0] rs2_data;
  logic [L-1:0]   wr_en = '0;
  logic [L*A-1:0] wr_addr = '0;
  logic [L*X-1:0] wr_data = '0;
  logic           wr_conflict;
  logic [A-1:0]   wr_conflict_reg;

  ixu_reg_file #(.NUM_LANES(L), .NUM_REGS(N), .XLEN(X), .AW(A)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_conflict(wr_conflict), .wr_conflict_reg(wr_conflict_reg)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc_n = 0;

  // Reference model: architectural registers, sticky flag, and inputs in flight
  logic [X-1:0] m [N];
  bit           m_conf = 1'b0;
  logic [A-1:0] m_creg = '0;
  bit           c_rst = 1'b0;
  bit   [L-1:0] c_wen = '0;
  logic [A-1:0] c_wa [L];
  logic [X-1:0] c_wd [L];

  function automatic logic [X-1:0] model_read(input logic [A-1:0] a);
    logic [X-1:0] v;
    if (!c_rst || a == 0) return '0;
    v = m[a];
    for (int l = 0; l < L; l++)
      if (c_wen[l] && c_wa[l] == a) v = c_wd[l];
    return v;
  endfunction

  // Apply the in-flight writes at a clock edge
  task automatic model_commit();
    int first;
    int cnt;
    if (!c_rst) return;
    first = -1;
    for (int a = 1; a < N; a++) begin
      cnt = 0;
      for (int l = 0; l < L; l++)
        if (c_wen[l] && int'(c_wa[l]) == a) cnt++;
      if (cnt >= 2 && first < 0) first = a;
    end
    if (first >= 0 && !m_conf) begin
      m_conf = 1'b1;
      m_creg = A'(first);
    end
    for (int l = 0; l < L; l++)
      if (c_wen[l] && c_wa[l] != 0) m[c_wa[l]] = c_wd[l];
  endtask

  // Driver: one cycle of stimulus, expected response pushed to the queue
  task automatic cyc(input bit r, input bit [1:0] we,
                     input logic [A-1:0] wa0, input logic [X-1:0] wd0,
                     input logic [A-1:0] wa1, input logic [X-1:0] wd1,
                     input logic [A-1:0] a10, input logic [A-1:0] a11,
                     input logic [A-1:0] a20, input logic [A-1:0] a21);
    logic [W-1:0] e;
    @(posedge clk);
    model_commit();
    #1;
    rst      = r;
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    rs1_addr = {a11, a10};
    rs2_addr = {a21, a20};
    c_rst = r;
    c_wen = we;
    c_wa[0] = wa0; c_wa[1] = wa1;
    c_wd[0] = wd0; c_wd[1] = wd1;
    if (!r) begin
      for (int i = 0; i < N; i++) m[i] = '0;
      m_conf = 1'b0;
      m_creg = '0;
    end
    e = {m_creg, m_conf, model_read(a21), model_read(a20), model_read(a11), model_read(a10)};
    exp_q.push_back(e);
    cyc_n++;
  endtask

  task automatic check(input string name, input logic [X-1:0] act, input logic [X-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc_n, act, req);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rs1_l0", rs1_data[X-1:0],   e[X-1:0]);
      check("rs1_l1", rs1_data[2*X-1:X], e[2*X-1:X]);
      check("rs2_l0", rs2_data[X-1:0],   e[3*X-1:2*X]);
      check("rs2_l1", rs2_data[2*X-1:X], e[4*X-1:3*X]);
      check("wr_conflict", X'(wr_conflict), X'(e[4*X]));
      check("wr_conflict_reg", X'(wr_conflict_reg), X'(e[W-1:4*X+1]));
    end
  end

  initial begin
    for (int i = 0; i < N; i++) m[i] = '0;
    for (int l = 0; l < L; l++) begin c_wa[l] = '0; c_wd[l] = '0; end

    // Reset then release
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 3, 5, 7, 1);

    // Basic write, bypass, then read on another lane next cycle
    cyc(1, 2'b01, 3, 32'h1234, 0, 0, 3, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3);

    // Mid-cycle async reset discards a pending write and clears r5
    cyc(1, 2'b01, 5, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 5, 5, 5, 5);
    cyc(0, 2'b01, 5, 32'hBEEF, 0, 0, 5, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 5, 3, 5, 3);

    // x0 writes from both lanes: never readable, never a conflict
    cyc(1, 2'b11, 0, 32'hFFFF_FFFF, 0, 32'h1, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Parallel writes to distinct registers
    cyc(1, 2'b11, 1, 32'h11, 2, 32'h22, 1, 2, 1, 2);
    cyc(1, 2'b00, 0, 0, 0, 0, 1, 1, 2, 2);

    // Conflict on r7, then a later conflict on r9 must not move the latch
    cyc(1, 2'b11, 7, 32'hAAAA, 7, 32'hBBBB, 7, 7, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 7, 7, 7, 7);
    cyc(1, 2'b11, 9, 32'h9999, 9, 32'h9A9A, 9, 0, 0, 9);
    cyc(1, 2'b00, 0, 0, 0, 0, 9, 7, 9, 7);

    // Held write through a stall, then back-to-back updates
    repeat (3) cyc(1, 2'b01, 4, 32'h44, 0, 0, 4, 4, 0, 0);
    cyc(1, 2'b01, 4, 32'h1, 0, 0, 0, 4, 0, 0);
    cyc(1, 2'b01, 4, 32'h2, 0, 0, 4, 4, 4, 4);
    cyc(1, 2'b00, 0, 0, 0, 0, 4, 4, 4, 4);

    // Reset again so random traffic can exercise a fresh first-conflict latch
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic on a narrow address range to provoke bypass and conflicts
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 59) != 0),
          2'($urandom_range(0, 3)),
          A'($urandom_range(0, 9)), $urandom,
          A'($urandom_range(0, 9)), $urandom,
          A'($urandom_range(0, 9)), A'($urandom_range(0, 9)),
          A'($urandom_range(0, 31)), A'($urandom_range(0, 31)));
    end

    // Drain: every pushed expectation must have been consumed
    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
